// File: rtl/sync_fifo_drain.sv
// sync_fifo_drain -- read-side controller for the sync FIFO.
//
// A start command drains exactly len words from the FIFO read port and
// forwards them on a valid/ready stream. The FIFO's one-cycle read latency is
// absorbed by a 2-entry skid buffer. Reads are only issued while the buffer
// has room for the returning word, so downstream back-pressure throttles the
// read strobe instead of dropping data.
//
// Optional feature: define SYNC_FIFO_DRAIN_TIMEOUT_EN to enable the idle
// watchdog. Without it the block waits indefinitely and timeout is tied low.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start, len          1-cycle command pulse and word count (taken in IDLE)
//   busy, done          command in progress / 1-cycle completion pulse
//   words_out           words delivered in the current or last command
//   fifo_empty          FIFO empty flag
//   fifo_rd_en          FIFO read strobe
//   fifo_read_data      FIFO data, valid the cycle after fifo_rd_en
//   m_valid, m_ready    downstream handshake
//   m_data, m_last      downstream data (buffer head), final-beat marker
//   timeout             1-cycle abort pulse (watchdog build only)
module sync_fifo_drain #(
  parameter int WIDTH   = 16,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_out,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, DRAIN, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] delivered;
  logic             rd_vld_p1;
  logic [WIDTH-1:0] buf_q [2];
  logic             head;
  logic [1:0]       occ;
  logic             hs;
  logic             last_hs;
  logic             credit;
  logic             rd_en;
  logic             abort;

  assign hs      = m_valid && m_ready;
  assign last_hs = hs && (delivered == len_q - LEN_W'(1));

  // A pop in the same cycle frees a slot, so the read can be issued against
  // it; that is what keeps a full-rate stream at one word per cycle while the
  // buffer plus the in-flight read never exceed two entries.
  assign credit = (occ == 2'd0) || (occ == 2'd1 && !rd_vld_p1) || hs;
  assign rd_en  = (state == DRAIN) && !fifo_empty && (issued < len_q) &&
                  credit && !abort;

  assign fifo_rd_en = rd_en;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign words_out  = delivered;
  assign m_valid    = (occ != 2'd0);
  assign m_data     = buf_q[head];
  assign m_last     = m_valid && (delivered == len_q - LEN_W'(1));
  assign timeout    = abort;

`ifdef SYNC_FIFO_DRAIN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt;

  assign abort = ((state == DRAIN) || (state == WAIT)) &&
                 (idle_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (((state != DRAIN) && (state != WAIT)) || rd_en || hs || abort) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? DONE : DRAIN;
      DRAIN: if (issued == len_q) state_nxt = WAIT;
      // The final handshake moves straight to DONE so done lands one cycle
      // after it rather than two.
      WAIT:  if ((delivered == len_q) || last_hs) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      issued    <= '0;
      delivered <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        len_q     <= len;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (rd_en) issued    <= issued + LEN_W'(1);
        if (hs)    delivered <= delivered + LEN_W'(1);
      end
    end
  end

  // Stage p0 -> p1: read strobe accepted by the FIFO, data returns next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_en;
    end
  end

  // Stage p1 -> buffer: returning word appended at the tail, head pops on
  // handshake. A flush also drops a word still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      head <= 1'b0;
    end else if (abort) begin
      occ  <= 2'd0;
      head <= 1'b0;
    end else begin
      case ({rd_vld_p1, hs})
        2'b10:   occ <= occ + 2'd1;
        2'b01: begin
          occ  <= occ - 2'd1;
          head <= ~head;
        end
        2'b11:   head <= ~head;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld_p1) buf_q[head ^ occ[0]] <= fifo_read_data;
  end

endmodule

// File: tb/tb_sync_fifo_drain.sv
`timescale 1ns/1ps
module tb_sync_fifo_drain;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, busy, done, fifo_empty, fifo_rd_en;
  logic             m_valid, m_ready, m_last, timeout;
  logic [LEN_W-1:0] len, words_out;
  logic [WIDTH-1:0] fifo_read_data, m_data;

  int errors = 0;
  int checks = 0;

  // Behavioural source FIFO: registered read, data valid the cycle after rd_en.
  logic [WIDTH-1:0] mem [1024];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_read_data <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always #5 clk = ~clk;

  sync_fifo_drain #(.WIDTH(WIDTH), .LEN_W(LEN_W), .TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .done(done), .words_out(words_out), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_read_data(fifo_read_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .timeout(timeout)
  );

  // Inputs change on the falling edge; outputs are sampled 1 ns before the
  // following rising edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush_src();
    wr_ptr = rd_ptr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; m_ready = 1'b0;
    push(16'h1234);
    repeat (2) tick();
    settle();
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0)    begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_last !== 1'b0)     begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (timeout !== 1'b0)    begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    checks++; if (words_out !== 8'd0)  begin errors++; $display("FAIL reset_words_out: got %0d want 0", words_out); end
    tick(); rst_n = 1'b1; settle();
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_idle_rd_en: got %b want 0", fifo_rd_en); end
    flush_src();
  endtask

  task automatic test_basic();
    int rd_cnt, first_rd, first_vld, nbeats, done_cnt, done_c;
    rd_cnt = 0; first_rd = -1; first_vld = -1; nbeats = 0; done_cnt = 0; done_c = -1;
    for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i));
    tick(); start = 1'b1; len = 8'd4; m_ready = 1'b1; settle();
    for (int c = 1; c <= 9; c++) begin
      tick(); start = 1'b0; settle();
      if (c == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      end
      if (fifo_rd_en) begin rd_cnt++; if (first_rd < 0) first_rd = c; end
      if (m_valid && first_vld < 0) first_vld = c;
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 16'hA000 + 16'(nbeats)) begin errors++; $display("FAIL basic_data: got %h want %h", m_data, 16'hA000 + 16'(nbeats)); end
        checks++; if (m_last !== (nbeats == 3)) begin errors++; $display("FAIL basic_last: got %b on beat %0d", m_last, nbeats); end
        nbeats++;
      end
      if (done) begin done_cnt++; done_c = c; end
    end
    checks++; if (rd_cnt != 4)    begin errors++; $display("FAIL basic_rd_count: got %0d want 4", rd_cnt); end
    checks++; if (first_rd != 1)  begin errors++; $display("FAIL basic_first_rd: got cycle %0d want 1", first_rd); end
    checks++; if (first_vld != 3) begin errors++; $display("FAIL basic_first_valid: got cycle %0d want 3", first_vld); end
    checks++; if (nbeats != 4)    begin errors++; $display("FAIL basic_beats: got %0d want 4", nbeats); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_c != 7)    begin errors++; $display("FAIL basic_done_cycle: got %0d want 7", done_c); end
    checks++; if (words_out !== 8'd4) begin errors++; $display("FAIL basic_words_out: got %0d want 4", words_out); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    checks++; if (wr_ptr - rd_ptr != 1) begin errors++; $display("FAIL basic_fifo_left: got %0d want 1", wr_ptr - rd_ptr); end
    flush_src();
  endtask

  task automatic test_back_pressure();
    int nbeats, rd_cnt, occ_m, infl_m, hs_i;
    logic seen_done, prev_stall;
    logic [WIDTH-1:0] prev_data;
    nbeats = 0; rd_cnt = 0; occ_m = 0; infl_m = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i < 6; i++) push(16'hB000 + 16'(i));
    tick(); start = 1'b1; len = 8'd6; m_ready = 1'b0; settle();
    for (int c = 1; c <= 60 && !seen_done; c++) begin
      tick(); start = 1'b0; m_ready = (c % 2 == 1); settle();
      if (c == 1) begin
        checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL bp_words_cleared: got %0d want 0", words_out); end
      end
      checks++; if (m_valid !== (occ_m != 0)) begin errors++; $display("FAIL bp_valid_occ: got %b want %b at cycle %0d", m_valid, occ_m != 0, c); end
      if (prev_stall) begin
        checks++; if (m_valid !== 1'b1 || m_data !== prev_data) begin errors++; $display("FAIL bp_stable: got %b/%h want 1/%h", m_valid, m_data, prev_data); end
      end
      hs_i = (m_valid && m_ready) ? 1 : 0;
      if (hs_i == 1) begin
        checks++; if (m_data !== 16'hB000 + 16'(nbeats)) begin errors++; $display("FAIL bp_data: got %h want %h", m_data, 16'hB000 + 16'(nbeats)); end
        nbeats++;
      end
      if (fifo_rd_en) rd_cnt++;
      checks++; if (occ_m + infl_m - hs_i + int'(fifo_rd_en) > 2) begin errors++; $display("FAIL bp_overflow: got occupancy %0d want <=2", occ_m + infl_m - hs_i + int'(fifo_rd_en)); end
      occ_m = occ_m + infl_m - hs_i;
      infl_m = int'(fifo_rd_en);
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (done) seen_done = 1'b1;
    end
    checks++; if (!seen_done)   begin errors++; $display("FAIL bp_done: got none want pulse within 60 cycles"); end
    checks++; if (nbeats != 6)  begin errors++; $display("FAIL bp_beats: got %0d want 6", nbeats); end
    checks++; if (rd_cnt != 6)  begin errors++; $display("FAIL bp_rd_count: got %0d want 6", rd_cnt); end
    checks++; if (words_out !== 8'd6) begin errors++; $display("FAIL bp_words_out: got %0d want 6", words_out); end
    tick(); m_ready = 1'b1; settle();
    flush_src();
  endtask

  task automatic test_empty_gaps();
    int nbeats, pushed, last_hs, done_c;
    nbeats = 0; pushed = 0; last_hs = -1; done_c = -1;
    tick(); start = 1'b1; len = 8'd3; m_ready = 1'b1; settle();
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      tick(); start = 1'b0;
      if (c % 4 == 2 && pushed < 3) begin push(16'hD000 + 16'(pushed)); pushed++; end
      settle();
      checks++; if (fifo_rd_en && fifo_empty) begin errors++; $display("FAIL gaps_rd_on_empty: got rd_en=1 with empty FIFO at cycle %0d", c); end
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 16'hD000 + 16'(nbeats)) begin errors++; $display("FAIL gaps_data: got %h want %h", m_data, 16'hD000 + 16'(nbeats)); end
        nbeats++; last_hs = c;
      end
      if (done) done_c = c;
    end
    checks++; if (nbeats != 3) begin errors++; $display("FAIL gaps_beats: got %0d want 3", nbeats); end
    checks++; if (done_c < 0 || done_c != last_hs + 1) begin errors++; $display("FAIL gaps_done_cycle: got %0d want %0d", done_c, last_hs + 1); end
  endtask

  task automatic test_len_zero();
    int bad;
    bad = 0;
    push(16'h5A5A);
    tick(); start = 1'b1; len = 8'd0; m_ready = 1'b1; settle();
    tick(); start = 1'b0; settle();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", done); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin tick(); settle(); end
      if (fifo_rd_en || m_valid) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL len0_activity: got %0d cycles with rd_en/m_valid want 0", bad); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL len0_idle: got done=%b busy=%b want 0/0", done, busy); end
    checks++; if (wr_ptr - rd_ptr != 1) begin errors++; $display("FAIL len0_fifo_left: got %0d want 1", wr_ptr - rd_ptr); end
    flush_src();
  endtask

  task automatic test_start_while_busy();
    int nbeats, done_cnt;
    nbeats = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
    tick(); start = 1'b1; len = 8'd2; m_ready = 1'b1; settle();
    for (int c = 1; c <= 12; c++) begin
      tick(); start = (c == 2); len = (c == 2) ? 8'd5 : 8'd2; settle();
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 16'hC000 + 16'(nbeats)) begin errors++; $display("FAIL busy_start_data: got %h want %h", m_data, 16'hC000 + 16'(nbeats)); end
        nbeats++;
      end
      if (done) done_cnt++;
    end
    checks++; if (nbeats != 2)   begin errors++; $display("FAIL busy_start_beats: got %0d want 2", nbeats); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done: got %0d want 1", done_cnt); end
    checks++; if (words_out !== 8'd2 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_end: got words=%0d busy=%b want 2/0", words_out, busy); end
    checks++; if (wr_ptr - rd_ptr != 2) begin errors++; $display("FAIL busy_start_fifo_left: got %0d want 2", wr_ptr - rd_ptr); end
    flush_src();
  endtask

  task automatic test_len_max();
    int nbeats;
    logic seen_done;
    nbeats = 0; seen_done = 1'b0;
    for (int i = 0; i < 255; i++) push(16'(i * 7 + 3));
    tick(); start = 1'b1; len = 8'd255; m_ready = 1'b1; settle();
    for (int c = 1; c <= 400 && !seen_done; c++) begin
      tick(); start = 1'b0; settle();
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 16'(nbeats * 7 + 3) || m_last !== (nbeats == 254)) begin errors++; $display("FAIL max_beat: got %h/%b want %h/%b", m_data, m_last, 16'(nbeats * 7 + 3), nbeats == 254); end
        nbeats++;
      end
      if (done) seen_done = 1'b1;
    end
    checks++; if (!seen_done)    begin errors++; $display("FAIL max_done: got none want pulse within 400 cycles"); end
    checks++; if (nbeats != 255) begin errors++; $display("FAIL max_beats: got %0d want 255", nbeats); end
    checks++; if (words_out !== 8'd255) begin errors++; $display("FAIL max_words_out: got %0d want 255", words_out); end
    flush_src();
  endtask

  task automatic test_reset_mid_op();
    int nbeats, done_cnt;
    nbeats = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) push(16'hE000 + 16'(i));
    tick(); start = 1'b1; len = 8'd4; m_ready = 1'b1; settle();
    for (int c = 1; c <= 20 && nbeats < 2; c++) begin
      tick(); start = 1'b0; settle();
      if (m_valid && m_ready) nbeats++;
    end
    tick(); rst_n = 1'b0; settle();
    tick(); rst_n = 1'b1; settle();
    checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL midrst_valid: got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (words_out !== 8'd0) begin errors++; $display("FAIL midrst_words_out: got %0d want 0", words_out); end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin tick(); settle(); end
      if (done) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
    flush_src();
    nbeats = 0; done_cnt = 0;
    push(16'hF000); push(16'hF001);
    tick(); start = 1'b1; len = 8'd2; settle();
    for (int c = 1; c <= 12; c++) begin
      tick(); start = 1'b0; settle();
      if (m_valid && m_ready) begin
        checks++; if (m_data !== 16'hF000 + 16'(nbeats)) begin errors++; $display("FAIL midrst_data: got %h want %h", m_data, 16'hF000 + 16'(nbeats)); end
        nbeats++;
      end
      if (done) done_cnt++;
    end
    checks++; if (nbeats != 2 || done_cnt != 1 || words_out !== 8'd2) begin errors++; $display("FAIL midrst_restart: got beats=%0d done=%0d words=%0d want 2/1/2", nbeats, done_cnt, words_out); end
  endtask

`ifdef SYNC_FIFO_DRAIN_TIMEOUT_EN
  task automatic test_timeout();
    int nbeats, done_cnt, to_c;
    nbeats = 0; done_cnt = 0; to_c = -1;
    push(16'h7000); push(16'h7001);
    tick(); start = 1'b1; len = 8'd4; m_ready = 1'b1; settle();
    for (int c = 1; c <= 40 && to_c < 0; c++) begin
      tick(); start = 1'b0; settle();
      if (m_valid && m_ready) nbeats++;
      if (done) done_cnt++;
      if (timeout) to_c = c;
    end
    checks++; if (to_c != 15)   begin errors++; $display("FAIL to_cycle: got %0d want 15", to_c); end
    checks++; if (nbeats != 2)  begin errors++; $display("FAIL to_beats: got %0d want 2", nbeats); end
    checks++; if (words_out !== 8'd2) begin errors++; $display("FAIL to_words_out: got %0d want 2", words_out); end
    tick(); settle();
    if (done) done_cnt++;
    checks++; if (done_cnt != 0 || busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_after: got done=%0d busy=%b timeout=%b want 0/0/0", done_cnt, busy, timeout); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_empty_gaps();
    test_len_zero();
    test_start_while_busy();
    test_len_max();
    test_reset_mid_op();
`ifdef SYNC_FIFO_DRAIN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
